// File: rtl/mprj_wb_pkg.sv
// Shared types and constants for the user-project Wishbone watchdog bridge.
package mprj_wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  // Bits needed to count 0..value-1; value is at least 2 here.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mprj_sat_counter.sv
// Saturating event counter with sticky flag; synchronous clear beats a same-cycle increment.
module mprj_sat_counter
  import mprj_wb_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             flag
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;

  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (clr) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (inc) begin
      flag_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign cnt  = cnt_q;
  assign flag = flag_q;

endmodule

// File: rtl/mprj_wb_watchdog.sv
// Wishbone bridge to the user slave that always terminates a cycle: slave ack, timeout or
// power-fail error. Slave strobe and core ack are registered from the current FSM state.
module mprj_wb_watchdog
  import mprj_wb_pkg::*;
#(
  parameter int          TIMEOUT  = 64,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEF,
  parameter int          CNT_W    = 8
) (
  input  logic             caravel_clk,
  input  logic             caravel_rstn,
  input  logic             mprj_cyc_o_user,
  input  logic             mprj_stb_o_user,
  input  logic             mprj_we_o_user,
  input  logic [3:0]       mprj_sel_o_user,
  input  logic [31:0]      mprj_adr_o_user,
  input  logic [31:0]      mprj_dat_o_user,
  output logic             mprj_ack_i_core,
  output logic [31:0]      mprj_dat_i_core,
  input  logic             user1_vcc_powergood,
  input  logic             user1_vdd_powergood,
  output logic             wbs_cyc_i,
  output logic             wbs_stb_i,
  output logic             wbs_we_i,
  output logic [3:0]       wbs_sel_i,
  output logic [31:0]      wbs_adr_i,
  output logic [31:0]      wbs_dat_i,
  input  logic             wbs_ack_o,
  input  logic [31:0]      wbs_dat_o,
  input  logic             timeout_clr,
  output logic             timeout_flag,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int              WCNT_W    = clog2(TIMEOUT);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       adr_q, adr_d;
  logic [31:0]       wdat_q, wdat_d;
  logic [31:0]       rsp_q, rsp_d;
  logic              bus_q, bus_d;
  logic              ack_q, ack_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              pg;
  logic              to_evt;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rsp_d   = rsp_q;
    to_evt  = 1'b0;
    pg      = user1_vcc_powergood & user1_vdd_powergood;
    bus_d   = (state_q == WAIT);
    ack_d   = (state_q == RESP);
    rdat_d  = (state_q == RESP) ? rsp_q : '0;

    case (state_q)
      IDLE: begin
        // ack_q high means we are in the gap cycle right after a response.
        if (mprj_cyc_o_user && mprj_stb_o_user && !ack_q) begin
          if (pg) begin
            we_d    = mprj_we_o_user;
            sel_d   = mprj_sel_o_user;
            adr_d   = mprj_adr_o_user;
            wdat_d  = mprj_dat_o_user;
            wcnt_d  = '0;
            state_d = WAIT;
          end else begin
            rsp_d   = ERR_DATA;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        if (wbs_ack_o) begin
          rsp_d   = we_q ? '0 : wbs_dat_o;
          state_d = RESP;
        end else if (!mprj_cyc_o_user) begin
          state_d = IDLE;
        end else if (!pg) begin
          rsp_d   = ERR_DATA;
          state_d = RESP;
        end else if (wcnt_q == WCNT_LAST) begin
          rsp_d   = ERR_DATA;
          to_evt  = 1'b1;
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge caravel_clk) begin
    if (!caravel_rstn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rsp_q   <= '0;
      bus_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rsp_q   <= rsp_d;
      bus_q   <= bus_d;
      ack_q   <= ack_d;
      rdat_q  <= rdat_d;
    end
  end

  mprj_sat_counter #(.CNT_W(CNT_W)) u_to_cnt (
    .clk  (caravel_clk),
    .rstn (caravel_rstn),
    .clr  (timeout_clr),
    .inc  (to_evt),
    .cnt  (timeout_count),
    .flag (timeout_flag)
  );

  assign wbs_cyc_i       = bus_q;
  assign wbs_stb_i       = bus_q;
  assign wbs_we_i        = we_q;
  assign wbs_sel_i       = sel_q;
  assign wbs_adr_i       = adr_q;
  assign wbs_dat_i       = wdat_q;
  assign mprj_ack_i_core = ack_q;
  assign mprj_dat_i_core = rdat_q;

endmodule

// File: tb/tb_mprj_wb_watchdog.sv
// Directed bench for mprj_wb_watchdog: driver pushes expected response data into a queue,
// a separate monitor pops and compares on every core-side ack.
module tb_mprj_wb_watchdog;

  logic        caravel_clk = 1'b0;
  logic        caravel_rstn = 1'b0;
  logic        mprj_cyc_o_user = 1'b0;
  logic        mprj_stb_o_user = 1'b0;
  logic        mprj_we_o_user = 1'b0;
  logic [3:0]  mprj_sel_o_user = '0;
  logic [31:0] mprj_adr_o_user = '0;
  logic [31:0] mprj_dat_o_user = '0;
  logic        mprj_ack_i_core;
  logic [31:0] mprj_dat_i_core;
  logic        user1_vcc_powergood = 1'b1;
  logic        user1_vdd_powergood = 1'b1;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic        wbs_ack_o = 1'b0;
  logic [31:0] wbs_dat_o = '0;
  logic        timeout_clr = 1'b0;
  logic        timeout_flag;
  logic [7:0]  timeout_count;

  int          vectors = 0;
  int          errors  = 0;
  logic [31:0] exp_q[$];

  // slave model configuration and observation
  logic        ack_en = 1'b0;
  int          ack_after = 0;
  int          scnt = 0;
  int          stb_last = 0;
  int          cyc_cycles = 0;
  int          ack_cnt = 0;

  mprj_wb_watchdog #(.TIMEOUT(64), .ERR_DATA(32'hDEAD_BEEF), .CNT_W(8)) dut (
    .caravel_clk(caravel_clk), .caravel_rstn(caravel_rstn),
    .mprj_cyc_o_user(mprj_cyc_o_user), .mprj_stb_o_user(mprj_stb_o_user),
    .mprj_we_o_user(mprj_we_o_user), .mprj_sel_o_user(mprj_sel_o_user),
    .mprj_adr_o_user(mprj_adr_o_user), .mprj_dat_o_user(mprj_dat_o_user),
    .mprj_ack_i_core(mprj_ack_i_core), .mprj_dat_i_core(mprj_dat_i_core),
    .user1_vcc_powergood(user1_vcc_powergood), .user1_vdd_powergood(user1_vdd_powergood),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .timeout_clr(timeout_clr), .timeout_flag(timeout_flag), .timeout_count(timeout_count)
  );

  always #5 caravel_clk = ~caravel_clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Slave: acks when the strobe has been seen high on ack_after consecutive samples.
  always @(negedge caravel_clk) begin
    if (!wbs_stb_i) begin
      if (scnt != 0) stb_last = scnt;
      scnt = 0;
    end else begin
      scnt++;
    end
    if (wbs_cyc_i) cyc_cycles++;
    wbs_ack_o = ack_en && wbs_stb_i && (scnt == ack_after);
  end

  // Monitor: every core ack must match the oldest expected response.
  always @(negedge caravel_clk) begin
    if (mprj_ack_i_core) begin
      ack_cnt++;
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_ack: got ack with data %h, required no ack", mprj_dat_i_core);
      end else begin
        check("ack_data", mprj_dat_i_core, exp_q.pop_front());
      end
    end else if (mprj_dat_i_core !== 32'h0) begin
      check("idle_data", mprj_dat_i_core, 32'h0);
    end
  end

  // Called at a negedge. Latency counts edges from the sampling edge (edge 0) to the ack edge.
  task automatic do_req(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                        input logic [3:0] sel, input logic [31:0] exp_dat,
                        input int exp_lat, input int clr_edge);
    int lat;
    lat = -1;
    exp_q.push_back(exp_dat);
    mprj_cyc_o_user = 1'b1;
    mprj_stb_o_user = 1'b1;
    mprj_we_o_user  = we;
    mprj_adr_o_user = adr;
    mprj_dat_o_user = wdat;
    mprj_sel_o_user = sel;
    for (int i = 0; i < 200; i++) begin
      @(negedge caravel_clk);
      timeout_clr = (i + 1 == clr_edge);
      if (mprj_ack_i_core) begin
        lat = i;
        break;
      end
    end
    timeout_clr     = 1'b0;
    mprj_cyc_o_user = 1'b0;
    mprj_stb_o_user = 1'b0;
    mprj_we_o_user  = 1'b0;
    check("latency", lat, exp_lat);
    @(negedge caravel_clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wbs_cyc"}, wbs_cyc_i, 0);
    check({tag, "_wbs_stb"}, wbs_stb_i, 0);
    check({tag, "_wbs_we"}, wbs_we_i, 0);
    check({tag, "_wbs_sel"}, wbs_sel_i, 0);
    check({tag, "_wbs_adr"}, wbs_adr_i, 0);
    check({tag, "_wbs_dat"}, wbs_dat_i, 0);
    check({tag, "_ack"}, mprj_ack_i_core, 0);
    check({tag, "_rdat"}, mprj_dat_i_core, 0);
    check({tag, "_flag"}, timeout_flag, 0);
    check({tag, "_count"}, timeout_count, 0);
  endtask

  initial begin
    int c0, a0;
    repeat (3) @(negedge caravel_clk);
    check_all_zero("reset");
    caravel_rstn = 1'b1;
    @(negedge caravel_clk);

    // Read acked 3 samples after strobe: sampled at edge 4, core ack at edge 5.
    ack_en = 1'b1; ack_after = 3; wbs_dat_o = 32'h1234_5678;
    do_req(1'b0, 32'h3000_0000, 32'h0, 4'hF, 32'h1234_5678, 5, -1);
    check("t1_count", timeout_count, 8'd0);
    check("t1_flag", timeout_flag, 0);

    // Write, slave silent: stb for 64 cycles, error ack at edge 65.
    ack_en = 1'b0;
    do_req(1'b1, 32'h3000_0004, 32'h0000_0F0F, 4'b1010, 32'hDEAD_BEEF, 65, -1);
    check("t2_stb_len", stb_last, 64);
    check("t2_flag", timeout_flag, 1);
    check("t2_count", timeout_count, 8'd1);
    check("t2_hold_adr", wbs_adr_i, 32'h3000_0004);
    check("t2_hold_dat", wbs_dat_i, 32'h0000_0F0F);
    check("t2_hold_sel", wbs_sel_i, 4'b1010);
    check("t2_hold_we", wbs_we_i, 1);

    // Power not good: slave untouched, error ack one edge after the sampling edge.
    user1_vdd_powergood = 1'b0;
    c0 = cyc_cycles;
    do_req(1'b0, 32'h3000_0008, 32'h0, 4'hF, 32'hDEAD_BEEF, 1, -1);
    check("t3_no_cyc", cyc_cycles - c0, 0);
    check("t3_count", timeout_count, 8'd1);
    user1_vdd_powergood = 1'b1;

    // Ack on the last wait cycle wins; one cycle later it is too late.
    ack_en = 1'b1; ack_after = 63; wbs_dat_o = 32'hCAFE_0001;
    do_req(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'hCAFE_0001, 65, -1);
    check("t4_count_same", timeout_count, 8'd1);
    ack_after = 64;
    do_req(1'b0, 32'h3000_000C, 32'h0, 4'hF, 32'hDEAD_BEEF, 65, -1);
    check("t4_count_late", timeout_count, 8'd2);

    // Acked write returns zero data even with slave data driven.
    ack_after = 2; wbs_dat_o = 32'h5555_AAAA;
    do_req(1'b1, 32'h3000_0010, 32'h1111_2222, 4'h3, 32'h0, 4, -1);

    // Master abort after wait cycle 10.
    ack_en = 1'b0;
    a0 = ack_cnt;
    mprj_cyc_o_user = 1'b1; mprj_stb_o_user = 1'b1; mprj_adr_o_user = 32'h3000_0014;
    repeat (11) @(negedge caravel_clk);
    mprj_cyc_o_user = 1'b0; mprj_stb_o_user = 1'b0;
    repeat (2) @(negedge caravel_clk);
    check("t5_cyc_dropped", wbs_cyc_i, 0);
    repeat (4) @(negedge caravel_clk);
    check("t5_no_ack", ack_cnt - a0, 0);
    check("t5_count", timeout_count, 8'd2);
    ack_en = 1'b1; ack_after = 1; wbs_dat_o = 32'h0BAD_F00D;
    do_req(1'b0, 32'h3000_0018, 32'h0, 4'hF, 32'h0BAD_F00D, 3, -1);

    // Saturation, then clear coinciding with a timeout.
    timeout_clr = 1'b1;
    @(negedge caravel_clk);
    timeout_clr = 1'b0;
    check("t6_clr_count", timeout_count, 8'd0);
    check("t6_clr_flag", timeout_flag, 0);
    ack_en = 1'b0;
    for (int n = 0; n < 255; n++)
      do_req(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'hDEAD_BEEF, 65, -1);
    check("t6_count_255", timeout_count, 8'hFF);
    do_req(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'hDEAD_BEEF, 65, -1);
    check("t6_count_sat", timeout_count, 8'hFF);
    check("t6_flag_sat", timeout_flag, 1);
    do_req(1'b0, 32'h3000_0020, 32'h0, 4'hF, 32'hDEAD_BEEF, 65, 64);
    check("t6_clr_win_count", timeout_count, 8'd0);
    check("t6_clr_win_flag", timeout_flag, 0);
    do_req(1'b0, 32'h3000_0024, 32'h0, 4'hF, 32'hDEAD_BEEF, 65, -1);
    check("t6_count_after", timeout_count, 8'd1);

    // Reset in the middle of a wait.
    mprj_cyc_o_user = 1'b1; mprj_stb_o_user = 1'b1; mprj_we_o_user = 1'b1;
    mprj_adr_o_user = 32'h3000_0028; mprj_dat_o_user = 32'h7777_7777; mprj_sel_o_user = 4'hF;
    repeat (10) @(negedge caravel_clk);
    check("t6_mid_wait_cyc", wbs_cyc_i, 1);
    caravel_rstn = 1'b0;
    mprj_cyc_o_user = 1'b0; mprj_stb_o_user = 1'b0; mprj_we_o_user = 1'b0;
    @(negedge caravel_clk);
    check_all_zero("midrst");
    caravel_rstn = 1'b1;
    @(negedge caravel_clk);
    ack_en = 1'b1; ack_after = 3; wbs_dat_o = 32'h1357_9BDF;
    do_req(1'b0, 32'h3000_002C, 32'h0, 4'hF, 32'h1357_9BDF, 5, -1);

    repeat (3) @(negedge caravel_clk);
    check("queue_drain", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
